// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the multichannel FIR MAC sequencer: state encoding
// and elaboration-time sizing helpers.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_MAC  = 2'd2,
    ST_DONE = 2'd3
  } fir_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  // Folding pairs tap k with tap NUM_COEF-1-k, so only the lower half is walked.
  function automatic int n_taps(input int num_coef, input int symmetric);
    return (symmetric != 0) ? (num_coef + 1) / 2 : num_coef;
  endfunction

endpackage

// File: rtl/fir_mc_sequencer_tap_counter.sv
// Saturating up-counter with a registered terminal-count flag, so the
// flag is usable in the same cycle the counter reaches MAX.
module tap_counter
  import fir_ctrl_pkg::*;
#(
  parameter int MAX = 16,
  parameter int W   = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_d, cnt_q;
  logic         last_d, last_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + W'(1);
    end
    last_d = (cnt_d == W'(MAX));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      last_q <= (MAX == 0);
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = last_q;

endmodule

// File: rtl/fir_mc_sequencer.sv
// Multichannel single-MAC FIR controller: accepts tagged samples, walks the
// taps, steers the shared accumulator and loads the per-channel result reg.
module fir_mc_sequencer
  import fir_ctrl_pkg::*;
#(
  parameter int NUM_COEF  = 17,
  parameter int NUM_CH    = 2,
  parameter int SYMMETRIC = 0,
  localparam int AW = clog2(NUM_COEF),
  localparam int CW = max1(clog2(NUM_CH))
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              val_in,
  input  logic [CW-1:0]     ch_in,
  input  logic              clr_ovr,
  output logic              in_ready,
  output logic              we_dline,
  output logic [CW-1:0]     ch_sel,
  output logic [AW-1:0]     addr,
  output logic [AW-1:0]     addr_b,
  output logic              mid_tap,
  output logic              rst_Acc,
  output logic              ce_Acc,
  output logic [NUM_CH-1:0] ce_Reg,
  output logic              val_out,
  output logic [CW-1:0]     ch_out,
  output logic              ovr
);

  localparam int            N_TAPS = n_taps(NUM_COEF, SYMMETRIC);
  localparam bit            MID_EN = (SYMMETRIC != 0) && ((NUM_COEF % 2) == 1);
  localparam logic [AW-1:0] MID    = AW'((NUM_COEF - 1) / 2);

  fir_state_e    state_d, state_q;
  logic [CW-1:0] ch_sel_d, ch_sel_q;
  logic          ovr_d, ovr_q;
  logic [AW-1:0] cnt;
  logic          last;
  logic          accept;
  logic          ch_ok;

  // Counter holds the MAC cycle index; cleared everywhere outside MAC.
  tap_counter #(
    .MAX (N_TAPS - 1),
    .W   (AW)
  ) u_tap_counter (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == ST_MAC),
    .clr  (state_q != ST_MAC),
    .cnt  (cnt),
    .last (last)
  );

  assign ch_ok = (32'(ch_in) < NUM_CH);

  always_comb begin
    state_d  = state_q;
    ch_sel_d = ch_sel_q;
    ovr_d    = ovr_q;
    in_ready = 1'b0;
    rst_Acc  = 1'b0;
    ce_Acc   = 1'b0;
    ce_Reg   = '0;
    val_out  = 1'b0;
    ch_out   = '0;
    addr     = '0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        rst_Acc  = 1'b1;
      end
      ST_LOAD: begin
        rst_Acc = 1'b1;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        ce_Acc = 1'b1;
        // Issue the next tap one cycle ahead; hold the final tap on the last cycle.
        addr   = last ? cnt : cnt + AW'(1);
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        in_ready = 1'b1;
        rst_Acc  = 1'b1;
        val_out  = 1'b1;
        ch_out   = ch_sel_q;
        ce_Reg   = NUM_CH'(1) << ch_sel_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    accept   = val_in && in_ready;
    we_dline = accept;
    if (accept) begin
      state_d  = ST_LOAD;
      ch_sel_d = ch_ok ? ch_in : '0;
    end

    if (val_in && !in_ready) ovr_d = 1'b1;
    else if (clr_ovr)        ovr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ch_sel_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_sel_q <= ch_sel_d;
      ovr_q    <= ovr_d;
    end
  end

  assign ch_sel  = ch_sel_q;
  assign ovr     = ovr_q;
  assign addr_b  = (SYMMETRIC != 0) ? AW'(NUM_COEF - 1) - addr : '0;
  assign mid_tap = MID_EN && (addr == MID);

endmodule

// File: tb/tb_fir_mc_sequencer.sv
// Random-stimulus bench: a plain and a folded sequencer share inputs and are
// checked every cycle against a timeline model (phase since accept).
module tb_fir_mc_sequencer;

  localparam int NC  = 17;
  localparam int NCH = 3;
  localparam int CW  = 2;
  localparam int AW  = 5;
  localparam int NCYC = 4800;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          val_in = 1'b0;
  logic          clr_ovr = 1'b0;
  logic [CW-1:0] ch_in = '0;

  logic [1:0]              in_ready, we_dline, mid_tap, rst_acc, ce_acc, val_out, ovr;
  logic [1:0][CW-1:0]      ch_sel, ch_out;
  logic [1:0][AW-1:0]      addr, addr_b;
  logic [1:0][NCH-1:0]     ce_reg;

  int n_tests = 0;
  int n_fail  = 0;

  int ph   [2];
  int mch  [2];
  bit movr [2];
  int ntap [2];
  bit sym  [2];

  always #5 clk = ~clk;

  fir_mc_sequencer #(.NUM_COEF(NC), .NUM_CH(NCH), .SYMMETRIC(0)) dut_plain (
    .clk(clk), .rst(rst), .val_in(val_in), .ch_in(ch_in), .clr_ovr(clr_ovr),
    .in_ready(in_ready[0]), .we_dline(we_dline[0]), .ch_sel(ch_sel[0]),
    .addr(addr[0]), .addr_b(addr_b[0]), .mid_tap(mid_tap[0]),
    .rst_Acc(rst_acc[0]), .ce_Acc(ce_acc[0]), .ce_Reg(ce_reg[0]),
    .val_out(val_out[0]), .ch_out(ch_out[0]), .ovr(ovr[0])
  );

  fir_mc_sequencer #(.NUM_COEF(NC), .NUM_CH(NCH), .SYMMETRIC(1)) dut_sym (
    .clk(clk), .rst(rst), .val_in(val_in), .ch_in(ch_in), .clr_ovr(clr_ovr),
    .in_ready(in_ready[1]), .we_dline(we_dline[1]), .ch_sel(ch_sel[1]),
    .addr(addr[1]), .addr_b(addr_b[1]), .mid_tap(mid_tap[1]),
    .rst_Acc(rst_acc[1]), .ce_Acc(ce_acc[1]), .ce_Reg(ce_reg[1]),
    .val_out(val_out[1]), .ch_out(ch_out[1]), .ovr(ovr[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_dut(input int i);
    int  n, ea;
    bit  ir, vo, mac;
    n   = ntap[i];
    ir  = (ph[i] == 0) || (ph[i] == n + 2);
    vo  = (ph[i] == n + 2);
    mac = (ph[i] >= 2) && (ph[i] <= n + 1);
    ea  = mac ? ((ph[i] - 1 < n - 1) ? ph[i] - 1 : n - 1) : 0;
    chk($sformatf("in_ready%0d", i), 32'(in_ready[i]), 32'(ir));
    chk($sformatf("we_dline%0d", i), 32'(we_dline[i]), 32'(val_in && ir));
    chk($sformatf("rst_acc%0d", i),  32'(rst_acc[i]),  32'(ir || ph[i] == 1));
    chk($sformatf("ce_acc%0d", i),   32'(ce_acc[i]),   32'(mac));
    chk($sformatf("addr%0d", i),     32'(addr[i]),     32'(ea));
    chk($sformatf("addr_b%0d", i),   32'(addr_b[i]),   sym[i] ? 32'(NC - 1 - ea) : 32'd0);
    chk($sformatf("mid_tap%0d", i),  32'(mid_tap[i]),  32'(sym[i] && ea == (NC - 1) / 2));
    chk($sformatf("val_out%0d", i),  32'(val_out[i]),  32'(vo));
    chk($sformatf("ce_reg%0d", i),   32'(ce_reg[i]),   vo ? (32'd1 << mch[i]) : 32'd0);
    chk($sformatf("ch_out%0d", i),   32'(ch_out[i]),   vo ? 32'(mch[i]) : 32'd0);
    chk($sformatf("ch_sel%0d", i),   32'(ch_sel[i]),   32'(mch[i]));
    chk($sformatf("ovr%0d", i),      32'(ovr[i]),      32'(movr[i]));
  endtask

  // Advance the model across the coming rising edge.
  task automatic step_model(input int i);
    int  n;
    bit  ir;
    n  = ntap[i];
    ir = (ph[i] == 0) || (ph[i] == n + 2);
    if (!rst) begin
      ph[i] = 0; mch[i] = 0; movr[i] = 1'b0;
    end else begin
      if (val_in && !ir) movr[i] = 1'b1;
      else if (clr_ovr)  movr[i] = 1'b0;
      if (val_in && ir) begin
        ph[i]  = 1;
        mch[i] = (int'(ch_in) < NCH) ? int'(ch_in) : 0;
      end else if (ph[i] == n + 2) begin
        ph[i] = 0;
      end else if (ph[i] > 0) begin
        ph[i]++;
      end
    end
  endtask

  initial begin
    int mode;
    ntap[0] = NC;           sym[0] = 1'b0;
    ntap[1] = (NC + 1) / 2; sym[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; mch[i] = 0; movr[i] = 1'b0;
    end
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      mode = (cyc / 400) % 4;
      rst  = (cyc < 2) ? 1'b0 : ($urandom_range(0, 249) != 0);
      case (mode)
        0:       val_in = ($urandom_range(0, 19) == 0);
        1:       val_in = ($urandom_range(0, 1) == 0);
        2:       val_in = 1'b1;
        default: val_in = ($urandom_range(0, 5) == 0);
      endcase
      if (!rst) val_in = 1'b0;
      ch_in   = CW'($urandom_range(0, 3));
      clr_ovr = ($urandom_range(0, 7) == 0);
      #1;
      if (cyc > 0) begin
        check_dut(0);
        check_dut(1);
      end
      step_model(0);
      step_model(1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
